// File: rtl/cart_load_ctrl.sv
// ROM download sequencer: routes the ioctl byte stream to the cart or BIOS RAM and parses the 7800 header.
// Define LOADER_CORE_WR_EN to add the core save-write port with core-first arbitration of the cart RAM port.
module cart_load_ctrl #(
    parameter int CART_AW = 18,
    parameter int BIOS_AW = 12,
    parameter int HDR_LEN = 128
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic [7:0]         ioctl_index,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic               ioctl_wr,
    output logic               ioctl_wait,
    input  logic               core_wr_req,
    input  logic [CART_AW-1:0] core_wr_addr,
    input  logic [7:0]         core_wr_data,
    output logic               core_wr_ack,
    output logic               cart_wr_en,
    output logic [CART_AW-1:0] cart_wr_addr,
    output logic [7:0]         cart_wr_data,
    output logic               bios_wr_en,
    output logic [BIOS_AW-1:0] bios_wr_addr,
    output logic [7:0]         bios_wr_data,
    output logic               cart_is_7800,
    output logic [15:0]        cart_flags,
    output logic [7:0]         joy0_type,
    output logic [7:0]         joy1_type,
    output logic [7:0]         cart_region,
    output logic [7:0]         cart_save,
    output logic [31:0]        cart_size,
    output logic               initial_pause,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [2:0] {IDLE, CART, BIOS, DRAIN, FINISH} state_t;

    state_t       state, state_next;
    logic         load_cart;
    logic         buf_valid;
    logic         buf_cart;
    logic [24:0]  buf_addr;
    logic [7:0]   buf_data;
    logic         sig_ok;
    logic [24:0]  last_addr;
    logic         core_grant;
    logic         buf_drain;
    logic         accept;
    logic         cart_entry;
    logic [CART_AW-1:0] cart_map;

`ifdef LOADER_CORE_WR_EN
    assign core_grant = core_wr_req;
`else
    logic unused_core;
    assign unused_core = ^{core_wr_req, core_wr_addr, core_wr_data};
    assign core_grant  = 1'b0;
`endif

    assign accept      = ioctl_wr && !buf_valid && (state == CART || state == BIOS);
    assign buf_drain   = buf_valid && (!buf_cart || !core_grant);
    assign cart_entry  = (state == IDLE) && (state_next == CART);
    assign core_wr_ack = core_grant;
    assign ioctl_wait  = buf_valid;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (ioctl_download) state_next = (ioctl_index != 8'd0) ? CART : BIOS;
            CART, BIOS: if (!ioctl_download) state_next = DRAIN;
            DRAIN:      if (!buf_valid) state_next = FINISH;
            FINISH:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // One-entry loader buffer; a strobe arriving while it is full is lost for good.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_cart  <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                buf_valid <= 1'b1;
                buf_cart  <= (state == CART);
                buf_addr  <= ioctl_addr;
                buf_data  <= ioctl_dout;
            end else if (buf_drain) begin
                buf_valid <= 1'b0;
            end
            if (ioctl_wr && buf_valid) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            load_cart    <= 1'b0;
            sig_ok       <= 1'b0;
            cart_is_7800 <= 1'b0;
            cart_flags   <= '0;
            joy0_type    <= '0;
            joy1_type    <= '0;
            cart_region  <= '0;
            cart_save    <= '0;
            last_addr    <= '0;
        end else if (state == IDLE && ioctl_download) begin
            load_cart <= (ioctl_index != 8'd0);
            if (cart_entry) begin
                sig_ok       <= 1'b0;
                cart_is_7800 <= 1'b0;
                cart_flags   <= '0;
                joy0_type    <= '0;
                joy1_type    <= '0;
                cart_region  <= '0;
                cart_save    <= '0;
                last_addr    <= '0;
            end
        end else if (accept && state == CART) begin
            last_addr <= ioctl_addr;
            // "ATARI" signature is tracked one byte at a time so no header copy is needed.
            case (ioctl_addr)
                25'd1:   sig_ok <= (ioctl_dout == 8'h41);
                25'd2:   sig_ok <= sig_ok && (ioctl_dout == 8'h54);
                25'd3:   sig_ok <= sig_ok && (ioctl_dout == 8'h41);
                25'd4:   sig_ok <= sig_ok && (ioctl_dout == 8'h52);
                25'd5:   cart_is_7800 <= sig_ok && (ioctl_dout == 8'h49);
                25'd53:  cart_flags[15:8] <= ioctl_dout;
                25'd54:  cart_flags[7:0]  <= ioctl_dout;
                25'd55:  joy0_type   <= ioctl_dout;
                25'd56:  joy1_type   <= ioctl_dout;
                25'd57:  cart_region <= ioctl_dout;
                25'd58:  cart_save   <= ioctl_dout;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cart_size     <= '0;
            initial_pause <= 1'b1;
        end else if (state == FINISH && load_cart) begin
            cart_size     <= {7'd0, last_addr} - (cart_is_7800 ? 32'(HDR_LEN) : 32'd0) + 32'd1;
            initial_pause <= 1'b0;
        end
    end

    // Header bytes land raw at their own address and are later overwritten by the payload.
    assign cart_map = (cart_is_7800 && buf_addr >= 25'(HDR_LEN)) ?
                      CART_AW'(buf_addr - 25'(HDR_LEN)) : CART_AW'(buf_addr);

    always_comb begin
        cart_wr_en   = 1'b0;
        cart_wr_addr = '0;
        cart_wr_data = '0;
        bios_wr_en   = 1'b0;
        bios_wr_addr = '0;
        bios_wr_data = '0;
        if (core_grant) begin
            cart_wr_en   = 1'b1;
            cart_wr_addr = core_wr_addr;
            cart_wr_data = core_wr_data;
        end else if (buf_valid && buf_cart) begin
            cart_wr_en   = 1'b1;
            cart_wr_addr = cart_map;
            cart_wr_data = buf_data;
        end
        if (buf_valid && !buf_cart) begin
            bios_wr_en   = 1'b1;
            bios_wr_addr = buf_addr[BIOS_AW-1:0];
            bios_wr_data = buf_data;
        end
    end

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Randomized bench for cart_load_ctrl: byte-level reference model, per-cycle compare, directed literal checks.
// Follows LOADER_CORE_WR_EN the same way the design does.
module tb_cart_load_ctrl;

    localparam int CART_AW = 18;
    localparam int BIOS_AW = 12;
    localparam int HDR_LEN = 128;
`ifdef LOADER_CORE_WR_EN
    localparam bit CORE_EN = 1'b1;
`else
    localparam bit CORE_EN = 1'b0;
`endif

    logic               clk_sys;
    logic               reset;
    logic               ioctl_download;
    logic [7:0]         ioctl_index;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic               ioctl_wr;
    logic               ioctl_wait;
    logic               core_wr_req;
    logic [CART_AW-1:0] core_wr_addr;
    logic [7:0]         core_wr_data;
    logic               core_wr_ack;
    logic               cart_wr_en;
    logic [CART_AW-1:0] cart_wr_addr;
    logic [7:0]         cart_wr_data;
    logic               bios_wr_en;
    logic [BIOS_AW-1:0] bios_wr_addr;
    logic [7:0]         bios_wr_data;
    logic               cart_is_7800;
    logic [15:0]        cart_flags;
    logic [7:0]         joy0_type;
    logic [7:0]         joy1_type;
    logic [7:0]         cart_region;
    logic [7:0]         cart_save;
    logic [31:0]        cart_size;
    logic               initial_pause;
    logic               busy;
    logic               overflow;

    cart_load_ctrl #(.CART_AW(CART_AW), .BIOS_AW(BIOS_AW), .HDR_LEN(HDR_LEN)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait),
        .core_wr_req(core_wr_req), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_wr_ack(core_wr_ack),
        .cart_wr_en(cart_wr_en), .cart_wr_addr(cart_wr_addr), .cart_wr_data(cart_wr_data),
        .bios_wr_en(bios_wr_en), .bios_wr_addr(bios_wr_addr), .bios_wr_data(bios_wr_data),
        .cart_is_7800(cart_is_7800), .cart_flags(cart_flags), .joy0_type(joy0_type),
        .joy1_type(joy1_type), .cart_region(cart_region), .cart_save(cart_save),
        .cart_size(cart_size), .initial_pause(initial_pause), .busy(busy), .overflow(overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit core_rand = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a downloaded byte is "pending" until the cart port is free of core traffic.
    logic        m_pend, m_pend_cart, m_overflow, m_is7800, m_pause, m_dl_prev, m_tgt_cart;
    logic [24:0] m_pend_addr, m_last;
    logic [7:0]  m_pend_data;
    logic [31:0] m_size;
    logic [7:0]  m_hdr [0:HDR_LEN-1];

    function automatic logic [CART_AW-1:0] map_cart(input logic [24:0] a, input logic is7800);
        logic [24:0] t;
        t = (is7800 && a >= 25'(HDR_LEN)) ? a - 25'(HDR_LEN) : a;
        return t[CART_AW-1:0];
    endfunction

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_pend     <= 1'b0;
            m_pend_cart <= 1'b0;
            m_pend_addr <= '0;
            m_pend_data <= '0;
            m_overflow <= 1'b0;
            m_is7800   <= 1'b0;
            m_last     <= '0;
            m_size     <= '0;
            m_pause    <= 1'b1;
            m_dl_prev  <= 1'b0;
            m_tgt_cart <= 1'b0;
            for (int i = 0; i < HDR_LEN; i++) m_hdr[i] <= 8'h00;
        end else begin
            m_dl_prev <= ioctl_download;
            if (ioctl_download && !m_dl_prev) begin
                m_tgt_cart <= (ioctl_index != 8'd0);
                if (ioctl_index != 8'd0) begin
                    m_is7800 <= 1'b0;
                    m_last   <= '0;
                    for (int i = 0; i < HDR_LEN; i++) m_hdr[i] <= 8'h00;
                end
            end
            if (!ioctl_download && m_dl_prev && m_tgt_cart) begin
                m_size  <= 32'(m_last) - (m_is7800 ? 32'(HDR_LEN) : 32'd0) + 32'd1;
                m_pause <= 1'b0;
            end
            if (m_pend) begin
                if (ioctl_wr) m_overflow <= 1'b1;
                if (!m_pend_cart || !(CORE_EN && core_wr_req)) m_pend <= 1'b0;
            end else if (ioctl_wr && ioctl_download) begin
                m_pend      <= 1'b1;
                m_pend_cart <= (ioctl_index != 8'd0);
                m_pend_addr <= ioctl_addr;
                m_pend_data <= ioctl_dout;
                if (ioctl_index != 8'd0) begin
                    m_last <= ioctl_addr;
                    if (ioctl_addr < 25'(HDR_LEN)) m_hdr[ioctl_addr[6:0]] <= ioctl_dout;
                    if (ioctl_addr == 25'd5)
                        m_is7800 <= ({m_hdr[1], m_hdr[2], m_hdr[3], m_hdr[4], ioctl_dout} == "ATARI");
                end
            end
        end
    end

    logic               exp_core, exp_cen, exp_ben;
    logic [CART_AW-1:0] exp_caddr;
    logic [7:0]         exp_cdata;
    assign exp_core  = CORE_EN && core_wr_req;
    assign exp_cen   = exp_core || (m_pend && m_pend_cart);
    assign exp_ben   = m_pend && !m_pend_cart;
    assign exp_caddr = exp_core ? core_wr_addr : map_cart(m_pend_addr, m_is7800);
    assign exp_cdata = exp_core ? core_wr_data : m_pend_data;

    always @(negedge clk_sys) begin
        if (chk_en) begin
            checkOutput("ioctl_wait", ioctl_wait, m_pend);
            checkOutput("core_wr_ack", core_wr_ack, exp_core);
            checkOutput("cart_wr_en", cart_wr_en, exp_cen);
            if (exp_cen) begin
                checkOutput("cart_wr_addr", cart_wr_addr, exp_caddr);
                checkOutput("cart_wr_data", cart_wr_data, exp_cdata);
            end
            checkOutput("bios_wr_en", bios_wr_en, exp_ben);
            if (exp_ben) begin
                checkOutput("bios_wr_addr", bios_wr_addr, m_pend_addr[BIOS_AW-1:0]);
                checkOutput("bios_wr_data", bios_wr_data, m_pend_data);
            end
            checkOutput("overflow", overflow, m_overflow);
        end
    end

    int bios_total = 0, cart_ld_total = 0, a5_total = 0, ack_total = 0, wait_total = 0;
    always @(negedge clk_sys) begin
        if (bios_wr_en) bios_total <= bios_total + 1;
        if (cart_wr_en && !core_wr_ack) cart_ld_total <= cart_ld_total + 1;
        if (cart_wr_en && !core_wr_ack && cart_wr_addr == '0 && cart_wr_data == 8'hA5)
            a5_total <= a5_total + 1;
        if (core_wr_ack) ack_total <= ack_total + 1;
        if (ioctl_wait) wait_total <= wait_total + 1;
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
        if (core_rand) begin
            core_wr_req  = ($urandom_range(0, 3) == 0);
            core_wr_addr = 18'h20000 | 18'($urandom_range(0, 16'hffff));
            core_wr_data = 8'($urandom);
        end
    endtask

    task automatic waitLow();
        int n = 0;
        while (ioctl_wait && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) checkOutput("ioctl_wait_timeout", ioctl_wait, 1'b0);
    endtask

    task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
        waitLow();
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        step();
        ioctl_wr = 1'b0;
        repeat ($urandom_range(0, 1)) step();
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        checkOutput("busy_cleared", busy, 1'b0);
    endtask

    // kind: 0 = BIOS/random, 1 = 7800 image, 2 = raw image without signature
    task automatic runLoad(input logic [7:0] idx, input int nbytes, input int kind, input int abort_at);
        logic [39:0] sig;
        logic [7:0]  d;
        sig = "ATARI";
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        step();
        step();
        for (int a = 0; a < nbytes; a++) begin
            if (a == abort_at) return;
            d = 8'($urandom);
            if (kind == 1 && a >= 1 && a <= 5) d = sig[8*(5-a) +: 8];
            if (kind == 1 && a == 128) d = 8'hA5;
            if (kind == 2 && a == 1) d = 8'h00;
            applyStimulus(25'(a), d);
        end
        ioctl_download = 1'b0;
        waitIdle();
    endtask

    task automatic checkLoad();
        checkOutput("cart_size", cart_size, m_size);
        checkOutput("initial_pause", initial_pause, m_pause);
        checkOutput("cart_is_7800", cart_is_7800, m_is7800);
        checkOutput("cart_flags", cart_flags, {m_hdr[53], m_hdr[54]});
        checkOutput("joy0_type", joy0_type, m_hdr[55]);
        checkOutput("joy1_type", joy1_type, m_hdr[56]);
        checkOutput("cart_region", cart_region, m_hdr[57]);
        checkOutput("cart_save", cart_save, m_hdr[58]);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap_b, snap_c, snap_a, snap_w, snap_5;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = '0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_wr = 1'b0;
        core_wr_req = 1'b0;
        core_wr_addr = '0;
        core_wr_data = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("reset_cart_size", cart_size, 32'd0);
        checkOutput("reset_initial_pause", initial_pause, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_overflow", overflow, 1'b0);
        checkOutput("reset_ioctl_wait", ioctl_wait, 1'b0);
        checkOutput("reset_is_7800", cart_is_7800, 1'b0);
        checkOutput("reset_cart_wr_en", cart_wr_en, 1'b0);
        checkOutput("reset_bios_wr_en", bios_wr_en, 1'b0);
        chk_en = 1'b1;
        reset = 1'b0;
        step();
        step();

        $display("[TB] BIOS load");
        core_rand = 1'b1;
        snap_b = bios_total;
        snap_c = cart_ld_total;
        runLoad(8'h00, 4096, 0, -1);
        checkLoad();
        checkOutput("bios_write_count", 32'(bios_total - snap_b), 32'd4096);
        checkOutput("bios_no_cart_writes", 32'(cart_ld_total - snap_c), 32'd0);
        checkOutput("bios_pause_held", initial_pause, 1'b1);
        checkOutput("bios_size_unchanged", cart_size, 32'd0);

        $display("[TB] 7800 image load");
        snap_5 = a5_total;
        runLoad(8'h01, 256, 1, -1);
        checkLoad();
        checkOutput("a7800_size", cart_size, 32'd128);
        checkOutput("a7800_detected", cart_is_7800, 1'b1);
        checkOutput("a7800_pause_released", initial_pause, 1'b0);
        checkOutput("a7800_payload_at_0", 32'(a5_total - snap_5 > 0), 32'd1);

        $display("[TB] raw image load");
        runLoad(8'h02, 4096, 2, -1);
        checkLoad();
        checkOutput("raw_size", cart_size, 32'd4096);
        checkOutput("raw_not_7800", cart_is_7800, 1'b0);

        $display("[TB] contention and overflow");
        core_rand = 1'b0;
        core_wr_req = 1'b0;
        ioctl_index = 8'h02;
        ioctl_download = 1'b1;
        step();
        step();
        for (int a = 0; a < 4; a++) applyStimulus(25'(a), (a == 1) ? 8'h00 : 8'($urandom));
        waitLow();
        step();
        snap_a = ack_total;
        snap_w = wait_total;
        snap_c = cart_ld_total;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd4;
        ioctl_dout = 8'h3C;
        step();
        ioctl_wr = 1'b0;
        core_wr_req = 1'b1;
        core_wr_addr = 18'h00100;
        core_wr_data = 8'h5A;
        repeat (3) step();
        core_wr_req = 1'b0;
        repeat (4) step();
        checkOutput("contention_acks", 32'(ack_total - snap_a), CORE_EN ? 32'd3 : 32'd0);
        checkOutput("contention_wait_cycles", 32'(wait_total - snap_w), CORE_EN ? 32'd4 : 32'd1);
        checkOutput("contention_loader_writes", 32'(cart_ld_total - snap_c), 32'd1);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd5;
        ioctl_dout = 8'($urandom);
        step();
        ioctl_addr = 25'd6;
        step();
        ioctl_wr = 1'b0;
        checkOutput("overflow_set", overflow, 1'b1);
        for (int a = 7; a < 16; a++) applyStimulus(25'(a), 8'($urandom));
        ioctl_download = 1'b0;
        waitIdle();
        checkLoad();
        checkOutput("short_load_size", cart_size, 32'd16);
        checkOutput("overflow_sticky", overflow, 1'b1);

        $display("[TB] reset during download");
        core_rand = 1'b1;
        runLoad(8'h03, 4096, 2, 1000);
        #3;
        core_rand = 1'b0;
        core_wr_req = 1'b0;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        #1;
        checkOutput("abort_cart_size", cart_size, 32'd0);
        checkOutput("abort_initial_pause", initial_pause, 1'b1);
        checkOutput("abort_overflow", overflow, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ioctl_wait", ioctl_wait, 1'b0);
        checkOutput("abort_cart_wr_en", cart_wr_en, 1'b0);
        checkOutput("abort_cart_flags", cart_flags, 16'h0000);
        step();
        step();
        reset = 1'b0;
        step();
        step();

        $display("[TB] reload after reset");
        core_rand = 1'b1;
        snap_5 = a5_total;
        runLoad(8'h01, 256, 1, -1);
        checkLoad();
        checkOutput("reload_size", cart_size, 32'd128);
        checkOutput("reload_detected", cart_is_7800, 1'b1);
        checkOutput("reload_pause_released", initial_pause, 1'b0);
        checkOutput("reload_payload_at_0", 32'(a5_total - snap_5 > 0), 32'd1);
        core_rand = 1'b0;
        core_wr_req = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
